find_leading_one_pipe: RTL
==========================

// Module: find_leading_one_pipe
// PURPOSE
//  Parametrised, pipelined leading-one / trailing-one detector with valid/ready handshake.
//  Returns the bit position and the leading/trailing zero count of a WIDTH-bit word.
//  Optionally outputs the normalised word.
//  Sits between the accumulator and the requant/float-convert stage of npu_v2.
//  Sustains 1 word/cycle with full backpressure support.
// PARAMETERS
//  WIDTH    32                  data width; power of 2, 8..256
//  GROUP_W  8                   stage-1 group width; power of 2, 2..WIDTH/2, divides WIDTH
//  POS_W    $clog2(WIDTH)       width of o_pos (derived, do not override)
//  CNT_W    $clog2(WIDTH)+1     width of o_count (derived; holds value WIDTH)
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       asynchronous active-low reset
//  i_valid   in   1       input word valid
//  o_ready   out  1       block can accept input this cycle
//  i_data    in   WIDTH   word to scan
//  i_mode    in   1       0: find MSB-most set bit; 1: find LSB-most set bit
//  o_valid   out  1       result valid
//  i_ready   in   1       downstream accepts result
//  o_pos     out  POS_W   bit index of the found one
//  o_count   out  CNT_W   mode0: leading-zero count; mode1: trailing-zero count
//  o_zero    out  1       i_data was all zero
//  o_norm    out  WIDTH   normalised word (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all pipeline valids, o_valid, o_pos, o_count, o_zero and o_norm go to 0 immediately.
//    Data registers also clear.
//  - Transfer rules:
//    - Input transfer occurs when i_valid & o_ready.
//    - Output transfer occurs when o_valid & i_ready.
//  - Pipeline: 2 register stages; latency is 2 cycles from input transfer to o_valid.
//  - S1 (coarse search):
//    - Registers i_data, i_mode and the per-group OR vector (WIDTH/GROUP_W bits).
//    - Registers the index of the selected group: highest non-zero group in mode0, lowest in mode1.
//  - S2 (fine search):
//    - Locates the one inside the selected group.
//    - Registers o_pos, o_count, o_zero and o_norm.
//  - Advance rules:
//    - S2 loads when !o_valid | i_ready.
//    - S1 loads when !s1_valid | S2 loads.
//    - o_ready = !s1_valid | S2 loads.
//    - o_ready is combinational from i_ready; no other comb path runs input to output.
//  - Stall: while o_valid & !i_ready, o_pos/o_count/o_zero/o_norm stay stable.
//    - Up to 2 words are held; none is lost, duplicated or reordered.
//  - Result arithmetic:
//    - mode0: o_count = WIDTH-1-o_pos.
//    - mode1: o_count = o_pos.
//  - All-zero input: o_zero=1, o_pos=0, o_count=WIDTH, o_norm=0, in either mode.
//  - i_mode is sampled with its data word; it may change every transfer.
//  - Reset mid-operation discards in-flight words; the first transfer after reset release is accepted normally.
// CONFIGURATION
//  FIND_LEADING_ONE_NORM_EN defined:
//    - mode0: o_norm = i_data << o_count; the found one lands at bit WIDTH-1.
//    - mode1: o_norm = i_data >> o_count; the found one lands at bit 0.
//    - The shift is done in S2 without adding latency.
//  FIND_LEADING_ONE_NORM_EN undefined:
//    - o_norm is tied to 0 and no shifter is built.
//    - Latency and all other outputs are unchanged.
// TESTING (WIDTH=32, GROUP_W=8; i_ready=1 unless stated)
//  1. i_data=0x0001_0000, mode0 -> 2 cycles later: o_pos=16, o_count=15, o_zero=0.
//  2. i_data=0x8000_0001: mode0 -> o_pos=31, o_count=0; then mode1 (next cycle) -> o_pos=0, o_count=0.
//     Outputs arrive back-to-back.
//  3. i_data=0x0 in both modes -> o_zero=1, o_pos=0, o_count=32, o_norm=0.
//  4. Backpressure: send 0x1, 0x2, 0x4, 0x8 (mode0) with i_ready=0 for cycles 0-5.
//     -> o_ready drops after 2 words are held.
//     -> After release, o_pos=0, 1, 2, 3 in order with no gaps or repeats.
//  5. Reset pulse (rst_n=0 for 1 cycle) with 2 words in flight.
//     -> o_valid=0 and outputs 0 immediately; the next word 0x0000_0100 returns o_pos=8, 2 cycles after accept.
//  6. NORM_EN: 0x0000_00F0 mode0 -> o_norm=0xF000_0000.
//     0x0000_00F0 mode1 -> o_norm=0x0000_000F.
//     Macro undefined -> o_norm=0 for both.

Source files
------------

// File: rtl/find_leading_one_pipe_if.sv
// Handshake bus for find_leading_one_pipe: input word/mode side and result side.
// slave is the detector's view, master is the producer/consumer view.
interface find_leading_one_pipe_if #(
   parameter int WIDTH = 32,
   parameter int POS_W = $clog2(WIDTH),
   parameter int CNT_W = $clog2(WIDTH) + 1
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data;
   logic             i_mode;
   logic             o_valid;
   logic             i_ready;
   logic [POS_W-1:0] o_pos;
   logic [CNT_W-1:0] o_count;
   logic             o_zero;
   logic [WIDTH-1:0] o_norm;

   modport slave  (input  i_valid, i_data, i_mode, i_ready,
                   output o_ready, o_valid, o_pos, o_count, o_zero, o_norm);
   modport master (output i_valid, i_data, i_mode, i_ready,
                   input  o_ready, o_valid, o_pos, o_count, o_zero, o_norm);
endinterface

// File: rtl/find_leading_one_pipe.sv
// Two-stage leading/trailing-one detector: S1 picks the group, S2 finds the bit.
// Define FIND_LEADING_ONE_NORM_EN to build the normalising shifter in S2.
module find_leading_one_pipe #(
   parameter int WIDTH   = 32,
   parameter int GROUP_W = 8,
   parameter int POS_W   = $clog2(WIDTH),
   parameter int CNT_W   = $clog2(WIDTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   find_leading_one_pipe_if.slave bus
);
   localparam int NG   = WIDTH / GROUP_W;
   localparam int GI_W = $clog2(NG);
   localparam int GP_W = $clog2(GROUP_W);

   // handshake
   logic w_s1_ld, w_s2_ld;
   logic r_s1_vld, r_o_valid;

   assign w_s2_ld     = !r_o_valid || bus.i_ready;
   assign w_s1_ld     = !r_s1_vld || w_s2_ld;
   assign bus.o_ready = w_s1_ld;
   assign bus.o_valid = r_o_valid;

   // S1: coarse search over group OR vector
   logic [NG-1:0]    w_gor;
   logic [GI_W-1:0]  w_gidx;
   logic [WIDTH-1:0] r_s1_data;
   logic             r_s1_mode;
   logic [NG-1:0]    r_s1_gor;
   logic [GI_W-1:0]  r_s1_gidx;

   for (genvar g = 0; g < NG; g++) begin : g_or
      assign w_gor[g] = |bus.i_data[g*GROUP_W +: GROUP_W];
   end

   // last hit wins: scan upward for the highest group, downward for the lowest
   always_comb begin
      w_gidx = '0;
      if (bus.i_mode) begin
         for (int g = NG-1; g >= 0; g--) if (w_gor[g]) w_gidx = GI_W'(g);
      end else begin
         for (int g = 0; g < NG; g++) if (w_gor[g]) w_gidx = GI_W'(g);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
         r_s1_mode <= 1'b0;
         r_s1_gor  <= '0;
         r_s1_gidx <= '0;
      end else if (w_s1_ld) begin
         r_s1_vld <= bus.i_valid;
         if (bus.i_valid) begin
            r_s1_data <= bus.i_data;
            r_s1_mode <= bus.i_mode;
            r_s1_gor  <= w_gor;
            r_s1_gidx <= w_gidx;
         end
      end
   end

   // S2: fine search inside the selected group
   logic [GROUP_W-1:0] w_grp;
   logic [GP_W-1:0]    w_bidx;
   logic               w_zero;
   logic [POS_W-1:0]   w_pos;
   logic [CNT_W-1:0]   w_cnt;

   assign w_grp = r_s1_data[r_s1_gidx*GROUP_W +: GROUP_W];

   always_comb begin
      w_bidx = '0;
      if (r_s1_mode) begin
         for (int b = GROUP_W-1; b >= 0; b--) if (w_grp[b]) w_bidx = GP_W'(b);
      end else begin
         for (int b = 0; b < GROUP_W; b++) if (w_grp[b]) w_bidx = GP_W'(b);
      end
   end

   assign w_zero = ~|r_s1_gor;
   assign w_pos  = w_zero ? '0 : {r_s1_gidx, w_bidx};
   assign w_cnt  = w_zero    ? CNT_W'(WIDTH) :
                   r_s1_mode ? {1'b0, w_pos} : CNT_W'(WIDTH-1) - {1'b0, w_pos};

   logic [POS_W-1:0] r_o_pos;
   logic [CNT_W-1:0] r_o_count;
   logic             r_o_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o_valid <= 1'b0;
         r_o_pos   <= '0;
         r_o_count <= '0;
         r_o_zero  <= 1'b0;
      end else if (w_s2_ld) begin
         r_o_valid <= r_s1_vld;
         if (r_s1_vld) begin
            r_o_pos   <= w_pos;
            r_o_count <= w_cnt;
            r_o_zero  <= w_zero;
         end
      end
   end

   assign bus.o_pos   = r_o_pos;
   assign bus.o_count = r_o_count;
   assign bus.o_zero  = r_o_zero;

`ifdef FIND_LEADING_ONE_NORM_EN
   // an all-zero word shifts to zero on its own, no special case needed
   logic [WIDTH-1:0] w_norm, r_o_norm;
   assign w_norm = r_s1_mode ? (r_s1_data >> w_cnt) : (r_s1_data << w_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    r_o_norm <= '0;
      else if (w_s2_ld && r_s1_vld)  r_o_norm <= w_norm;
   end
   assign bus.o_norm = r_o_norm;
`else
   assign bus.o_norm = '0;
`endif

endmodule
